// File: rtl/dmem_hs.sv
// rtl/dmem_hs.sv - byte-addressed data memory with valid/ready request and response channels
// Define DMEM_HS_ALIGN_CHECK_EN to reject word-straddling accesses instead of splitting them into two beats.
module dmem_hs #(
   parameter int MEM_SIZE   = 256,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_we,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [DATA_WIDTH-1:0]   i_req_wdata,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_req_wstrb,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
   output logic                    o_rsp_err
);
   localparam int NB = DATA_WIDTH / BYTE_WIDTH;
   localparam int LG = $clog2(NB);
   localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam int AW = IW + LG;
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE * NB);

   typedef enum logic [1:0] {IDLE, BEAT2, RESP} state_t;

   state_t                state_q;
   logic                  rsp_valid_q, rsp_err_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic [AW-1:0]         addr_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [NB-1:0]         wstrb_q;
   logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE] = '{default: '0};

   logic                  acc, beat2, do_beat;
   logic [ADDR_WIDTH:0]   hi_w, top;
   logic                  wspan, span, range_err, req_err, req_span;
   logic [AW-1:0]         cur_addr;
   logic [LG-1:0]         off, src, pos;
   logic [IW-1:0]         w_idx;
   logic [NB-1:0]         cur_wstrb, rot_strb, in_beat, mem_we;
   logic [DATA_WIDTH-1:0] cur_wdata, rot_wdata, rd_word, beat_rdata;

   assign beat2       = (state_q == BEAT2);
   assign o_req_ready = i_rst_n && ((state_q == IDLE) || ((state_q == RESP) && i_rsp_ready));
   assign acc         = i_req_valid && o_req_ready;
   assign do_beat     = i_rst_n && (acc || beat2);

   // Span and range classification of the incoming request; range math is one bit wider so wrap is an error.
   always_comb begin
      hi_w  = '0;
      wspan = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (i_req_wstrb[i]) begin
            hi_w = (ADDR_WIDTH+1)'(i);
            if ((LG+1)'(i_req_addr[LG-1:0]) + (LG+1)'(i) >= (LG+1)'(NB)) wspan = 1'b1;
         end
      end
      if (!i_req_we) hi_w = (ADDR_WIDTH+1)'(NB - 1);
      top       = {1'b0, i_req_addr} + hi_w;
      range_err = (top >= LIMIT) && (!i_req_we || (|i_req_wstrb));
      span      = i_req_we ? wspan : (i_req_addr[LG-1:0] != '0);
`ifdef DMEM_HS_ALIGN_CHECK_EN
      req_err  = range_err || span;
      req_span = 1'b0;
`else
      req_err  = range_err;
      req_span = span && !range_err;
`endif
   end

   // One beat touches one word: lanes j>=off belong to the low word, lanes j<off to the high word.
   always_comb begin
      cur_addr  = beat2 ? addr_q  : i_req_addr[AW-1:0];
      cur_wdata = beat2 ? wdata_q : i_req_wdata;
      cur_wstrb = beat2 ? wstrb_q : i_req_wstrb;
      off       = cur_addr[LG-1:0];
      w_idx     = cur_addr[AW-1:LG] + IW'(beat2);
      rd_word   = mem_q[w_idx];
      rot_wdata = '0;
      rot_strb  = '0;
      in_beat   = '0;
      mem_we    = '0;
      for (int j = 0; j < NB; j++) begin
         src          = LG'(j) - off;
         in_beat[j]   = beat2 ? (LG'(j) < off) : (LG'(j) >= off);
         rot_wdata[j*BYTE_WIDTH +: BYTE_WIDTH] = cur_wdata[src*BYTE_WIDTH +: BYTE_WIDTH];
         rot_strb[j]  = cur_wstrb[src];
         mem_we[j]    = do_beat && (beat2 ? we_q : (i_req_we && !req_err)) && rot_strb[j] && in_beat[j];
      end
      beat_rdata = '0;
      for (int i = 0; i < NB; i++) begin
         pos = LG'(i) + off;
         if (in_beat[pos])
            beat_rdata[i*BYTE_WIDTH +: BYTE_WIDTH] = rd_word[pos*BYTE_WIDTH +: BYTE_WIDTH];
         else if (beat2)
            beat_rdata[i*BYTE_WIDTH +: BYTE_WIDTH] = rsp_rdata_q[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   always_ff @(posedge i_clk) begin
      for (int j = 0; j < NB; j++)
         if (mem_we[j]) mem_q[w_idx][j*BYTE_WIDTH +: BYTE_WIDTH] <= rot_wdata[j*BYTE_WIDTH +: BYTE_WIDTH];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
      end else begin
         case (state_q)
            BEAT2: begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= we_q ? '0 : beat_rdata;
            end
            default: begin
               if ((state_q == RESP) && i_rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
               end
               if (acc) begin
                  addr_q    <= i_req_addr[AW-1:0];
                  we_q      <= i_req_we;
                  wdata_q   <= i_req_wdata;
                  wstrb_q   <= i_req_wstrb;
                  rsp_err_q <= req_err;
                  if (req_err) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else begin
                     state_q     <= req_span ? BEAT2 : RESP;
                     rsp_valid_q <= !req_span;
                     rsp_rdata_q <= i_req_we ? '0 : beat_rdata;
                  end
               end
            end
         endcase
      end
   end

   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_hs.sv
// tb/tb_dmem_hs.sv - directed self-checking bench for dmem_hs
module tb_dmem_hs;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   int          n_checks = 0;
   int          n_err    = 0;

   always #5 clk = ~clk;

   dmem_hs #(.MEM_SIZE(256), .DATA_WIDTH(32), .ADDR_WIDTH(32), .BYTE_WIDTH(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One request with response consumed immediately; latency counted in edges from accept.
   task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
      rsp_ready = 1'b1;
      #1 check({tag, "/ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "/lat"},   32'(lat),     32'(exp_lat));
      check({tag, "/rdata"}, rsp_rdata,    exp_rdata);
      check({tag, "/err"},   32'(rsp_err), 32'(exp_err));
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_wstrb = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst/valid", 32'(rsp_valid), 32'd0);
      check("rst/rdata", rsp_rdata,       32'd0);
      check("rst/err",   32'(rsp_err),   32'd0);
      check("rst/ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      #1 check("rst/ready_rel", 32'(req_ready), 32'd1);

      do_req("wr10",  1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, 1'b0);
      do_req("rd10",  1'b0, 32'h10, 32'h0,        4'h0, 1, 32'hDEADBEEF, 1'b0);
      do_req("wr20",  1'b1, 32'h20, 32'h11223344, 4'hF, 1, 32'h0, 1'b0);
      do_req("wr20p", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 32'h0, 1'b0);
      do_req("rd20",  1'b0, 32'h20, 32'h0,        4'h0, 1, 32'h11BB33DD, 1'b0);
      do_req("wr10z", 1'b1, 32'h10, 32'h12345678, 4'h0, 1, 32'h0, 1'b0);
      do_req("rd10z", 1'b0, 32'h10, 32'h0,        4'h0, 1, 32'hDEADBEEF, 1'b0);

`ifdef DMEM_HS_ALIGN_CHECK_EN
      do_req("wr32",  1'b1, 32'h32, 32'h55667788, 4'hF, 1, 32'h0, 1'b1);
      do_req("rd30",  1'b0, 32'h30, 32'h0,        4'h0, 1, 32'h0, 1'b0);
      do_req("rd34",  1'b0, 32'h34, 32'h0,        4'h0, 1, 32'h0, 1'b0);
      do_req("rd32",  1'b0, 32'h32, 32'h0,        4'h0, 1, 32'h0, 1'b1);
`else
      do_req("wr32",  1'b1, 32'h32, 32'h55667788, 4'hF, 2, 32'h0, 1'b0);
      do_req("rd30",  1'b0, 32'h30, 32'h0,        4'h0, 1, 32'h77880000, 1'b0);
      do_req("rd34",  1'b0, 32'h34, 32'h0,        4'h0, 1, 32'h00005566, 1'b0);
      do_req("rd32",  1'b0, 32'h32, 32'h0,        4'h0, 2, 32'h55667788, 1'b0);
`endif

      do_req("rd3fc",  1'b0, 32'h3FC, 32'h0,        4'h0, 1, 32'h0, 1'b0);
      do_req("wr3fc",  1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 1, 32'h0, 1'b0);
      do_req("rd3fe",  1'b0, 32'h3FE, 32'h0,        4'h0, 1, 32'h0, 1'b1);
      do_req("wr3fe",  1'b1, 32'h3FE, 32'h99999999, 4'hF, 1, 32'h0, 1'b1);
      do_req("rd3fc2", 1'b0, 32'h3FC, 32'h0,        4'h0, 1, 32'hCAFEF00D, 1'b0);
      do_req("rdwrap", 1'b0, 32'hFFFFFFFE, 32'h0,   4'h0, 1, 32'h0, 1'b1);

      // Backpressure: a second request is held while the response stalls, then streams.
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
      @(posedge clk); #1;
      req_addr = 32'h20;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("bp/valid", 32'(rsp_valid), 32'd1);
         check("bp/rdata", rsp_rdata,       32'hDEADBEEF);
         check("bp/err",   32'(rsp_err),   32'd0);
         check("bp/ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      #1 check("bp/ready_rel", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      check("st0/valid", 32'(rsp_valid), 32'd1);
      check("st0/rdata", rsp_rdata,       32'h11BB33DD);
      req_addr = 32'h3FC;
      @(posedge clk); #1;
      check("st1/valid", 32'(rsp_valid), 32'd1);
      check("st1/rdata", rsp_rdata,       32'hCAFEF00D);
      req_addr = 32'h10;
      @(posedge clk); #1;
      check("st2/valid", 32'(rsp_valid), 32'd1);
      check("st2/rdata", rsp_rdata,       32'hDEADBEEF);
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("st3/valid", 32'(rsp_valid), 32'd0);

`ifndef DMEM_HS_ALIGN_CHECK_EN
      // Reset lands while the high-word beat is pending.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h32; req_wdata = 32'hA1B2C3D4; req_wstrb = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      check("rb2/valid", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      #1 check("rb2/ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      check("rb2/valid2", 32'(rsp_valid), 32'd0);
      do_req("rb2/rd30", 1'b0, 32'h30, 32'h0, 4'h0, 1, 32'hC3D40000, 1'b0);
      do_req("rb2/rd34", 1'b0, 32'h34, 32'h0, 4'h0, 1, 32'h00005566, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
